// File: rtl/axi_lite_arb2.sv
// axi_lite_arb2
// -----------------------------------------------------------------------------
// Two-master, one-slave AXI4-Lite arbiter. Master 0 is the instruction fetch
// unit and master 1 is the load/store unit. Both share a single memory slave.
// The arbiter serialises their traffic so that the slave only ever sees one
// outstanding transaction, read or write. Masters are chosen round-robin when
// both request. Each response is steered back to the master that issued the
// request.
//
// Ports
//   clk, rst                  clock and asynchronous active-high reset
//   m0_* / m1_*               full AXI4-Lite slave-side ports for each master
//                             (AR, R, AW, W, B channels)
//   s_*                       AXI4-Lite master-side port to the shared slave
//   grant                     one-hot owner of the current transaction,
//                             2'b00 while idle (debug / performance counters)
//
// Behaviour summary
//   - A read request is m<i>_arvalid. A write request needs both m<i>_awvalid
//     and m<i>_wvalid, because the slave takes AW and W in the same cycle.
//   - One cycle of arbitration is spent in IDLE. After that, every channel is
//     forwarded combinationally for the owner. The non-owner sees zero on all
//     of its ready/valid outputs.
//   - The arbiter returns to IDLE only on the response handshake (R or B).
// -----------------------------------------------------------------------------
module axi_lite_arb2 #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,

   // master 0 (instruction fetch)
   input  logic [ADDR_W-1:0]     m0_araddr,
   input  logic                  m0_arvalid,
   output logic                  m0_arready,
   output logic [DATA_W-1:0]     m0_rdata,
   output logic [1:0]            m0_rresp,
   output logic                  m0_rvalid,
   input  logic                  m0_rready,
   input  logic [ADDR_W-1:0]     m0_awaddr,
   input  logic                  m0_awvalid,
   output logic                  m0_awready,
   input  logic [DATA_W-1:0]     m0_wdata,
   input  logic [DATA_W/8-1:0]   m0_wstrb,
   input  logic                  m0_wvalid,
   output logic                  m0_wready,
   output logic [1:0]            m0_bresp,
   output logic                  m0_bvalid,
   input  logic                  m0_bready,

   // master 1 (load/store)
   input  logic [ADDR_W-1:0]     m1_araddr,
   input  logic                  m1_arvalid,
   output logic                  m1_arready,
   output logic [DATA_W-1:0]     m1_rdata,
   output logic [1:0]            m1_rresp,
   output logic                  m1_rvalid,
   input  logic                  m1_rready,
   input  logic [ADDR_W-1:0]     m1_awaddr,
   input  logic                  m1_awvalid,
   output logic                  m1_awready,
   input  logic [DATA_W-1:0]     m1_wdata,
   input  logic [DATA_W/8-1:0]   m1_wstrb,
   input  logic                  m1_wvalid,
   output logic                  m1_wready,
   output logic [1:0]            m1_bresp,
   output logic                  m1_bvalid,
   input  logic                  m1_bready,

   // shared slave
   output logic [ADDR_W-1:0]     s_araddr,
   output logic                  s_arvalid,
   input  logic                  s_arready,
   input  logic [DATA_W-1:0]     s_rdata,
   input  logic [1:0]            s_rresp,
   input  logic                  s_rvalid,
   output logic                  s_rready,
   output logic [ADDR_W-1:0]     s_awaddr,
   output logic                  s_awvalid,
   input  logic                  s_awready,
   output logic [DATA_W-1:0]     s_wdata,
   output logic [DATA_W/8-1:0]   s_wstrb,
   output logic                  s_wvalid,
   input  logic                  s_wready,
   input  logic [1:0]            s_bresp,
   input  logic                  s_bvalid,
   output logic                  s_bready,

   // debug
   output logic [1:0]            grant
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_RD_ADDR = 3'd1;
   localparam logic [2:0] ST_RD_DATA = 3'd2;
   localparam logic [2:0] ST_WR_ADDR = 3'd3;
   localparam logic [2:0] ST_WR_RESP = 3'd4;

   logic [2:0]          state_q, state_d;
   logic                owner_q, owner_d;
   logic                lastOwner_q, lastOwner_d;
   logic [1:0]          grant_q, grant_d;

   logic                rdReq0, rdReq1;
   logic                wrReq0, wrReq1;
   logic                anyReq0, anyReq1;
   logic                pick;
   logic                pickRead;

   logic [ADDR_W-1:0]   ownAraddr;
   logic                ownArvalid;
   logic                ownRready;
   logic [ADDR_W-1:0]   ownAwaddr;
   logic                ownAwvalid;
   logic [DATA_W-1:0]   ownWdata;
   logic [DATA_W/8-1:0] ownWstrb;
   logic                ownWvalid;
   logic                ownBready;

   logic                inRdAddr, inRdData, inWrAddr, inWrResp;
   logic                wrJointValid;
   logic                wrJointReady;

   // Request decode. A write with only one of AW/W valid is not a request yet.
   // Ignoring it lets the other master be served while the half-formed write
   // waits for its second half.
   assign rdReq0  = m0_arvalid;
   assign rdReq1  = m1_arvalid;
   assign wrReq0  = m0_awvalid & m0_wvalid;
   assign wrReq1  = m1_awvalid & m1_wvalid;
   assign anyReq0 = rdReq0 | wrReq0;
   assign anyReq1 = rdReq1 | wrReq1;

   // Round-robin winner. On a tie, the master that did not own the previous
   // transaction wins. Otherwise the only requester wins.
   assign pick     = (anyReq0 & anyReq1) ? ~lastOwner_q : anyReq1;
   // Within the winning master, a read is preferred over a write.
   assign pickRead = pick ? rdReq1 : rdReq0;

   // Owner-side request mux. It is driven from owner_q in every state. The
   // valid outputs are gated by state further down, so payloads never need
   // their own gating.
   assign ownAraddr  = owner_q ? m1_araddr  : m0_araddr;
   assign ownArvalid = owner_q ? m1_arvalid : m0_arvalid;
   assign ownRready  = owner_q ? m1_rready  : m0_rready;
   assign ownAwaddr  = owner_q ? m1_awaddr  : m0_awaddr;
   assign ownAwvalid = owner_q ? m1_awvalid : m0_awvalid;
   assign ownWdata   = owner_q ? m1_wdata   : m0_wdata;
   assign ownWstrb   = owner_q ? m1_wstrb   : m0_wstrb;
   assign ownWvalid  = owner_q ? m1_wvalid  : m0_wvalid;
   assign ownBready  = owner_q ? m1_bready  : m0_bready;

   assign inRdAddr = (state_q == ST_RD_ADDR);
   assign inRdData = (state_q == ST_RD_DATA);
   assign inWrAddr = (state_q == ST_WR_ADDR);
   assign inWrResp = (state_q == ST_WR_RESP);

   // AW and W are presented to the slave as one joint transfer. Each side only
   // sees ready when the slave can take both halves in the same cycle.
   assign wrJointValid = inWrAddr & ownAwvalid & ownWvalid;
   assign wrJointReady = s_awready & s_wready;

   // Next-state logic. Owner and round-robin history change only when a
   // transaction is granted in IDLE. grant is registered alongside the state
   // so that it reads 0 in exactly the cycles the arbiter is idle.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      lastOwner_d = lastOwner_q;
      grant_d     = grant_q;
      case (state_q)
         ST_IDLE: begin
            if (anyReq0 | anyReq1) begin
               owner_d     = pick;
               lastOwner_d = pick;
               grant_d     = pick ? 2'b10 : 2'b01;
               state_d     = pickRead ? ST_RD_ADDR : ST_WR_ADDR;
            end
         end
         ST_RD_ADDR: begin
            if (s_arvalid & s_arready) begin
               state_d = ST_RD_DATA;
            end
         end
         ST_RD_DATA: begin
            if (s_rvalid & s_rready) begin
               state_d = ST_IDLE;
               grant_d = 2'b00;
            end
         end
         ST_WR_ADDR: begin
            if (s_awvalid & wrJointReady) begin
               state_d = ST_WR_RESP;
            end
         end
         ST_WR_RESP: begin
            if (s_bvalid & s_bready) begin
               state_d = ST_IDLE;
               grant_d = 2'b00;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
         end
      endcase
   end

   // State registers. Reset favours master 0 on the first tie by pretending
   // master 1 owned the last transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         owner_q     <= 1'b0;
         lastOwner_q <= 1'b1;
         grant_q     <= 2'b00;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         lastOwner_q <= lastOwner_d;
         grant_q     <= grant_d;
      end
   end

   // Slave-side outputs. Payloads always come from the owner mux. Valid and
   // ready are asserted only in the phase that uses them.
   assign s_araddr  = ownAraddr;
   assign s_arvalid = inRdAddr & ownArvalid;
   assign s_rready  = inRdData & ownRready;
   assign s_awaddr  = ownAwaddr;
   assign s_wdata   = ownWdata;
   assign s_wstrb   = ownWstrb;
   assign s_awvalid = wrJointValid;
   assign s_wvalid  = wrJointValid;
   assign s_bready  = inWrResp & ownBready;

   // Master-side outputs. Response payloads are broadcast to both masters
   // unmodified. Only the owner ever sees a valid or ready.
   assign m0_arready = inRdAddr & ~owner_q & s_arready;
   assign m0_rdata   = s_rdata;
   assign m0_rresp   = s_rresp;
   assign m0_rvalid  = inRdData & ~owner_q & s_rvalid;
   assign m0_awready = inWrAddr & ~owner_q & wrJointReady;
   assign m0_wready  = inWrAddr & ~owner_q & wrJointReady;
   assign m0_bresp   = s_bresp;
   assign m0_bvalid  = inWrResp & ~owner_q & s_bvalid;

   assign m1_arready = inRdAddr & owner_q & s_arready;
   assign m1_rdata   = s_rdata;
   assign m1_rresp   = s_rresp;
   assign m1_rvalid  = inRdData & owner_q & s_rvalid;
   assign m1_awready = inWrAddr & owner_q & wrJointReady;
   assign m1_wready  = inWrAddr & owner_q & wrJointReady;
   assign m1_bresp   = s_bresp;
   assign m1_bvalid  = inWrResp & owner_q & s_bvalid;

   assign grant = grant_q;

endmodule

// File: tb/tb_axi_lite_arb2.sv
// tb_axi_lite_arb2
// -----------------------------------------------------------------------------
// Randomised self-checking bench for axi_lite_arb2. The two masters and the
// slave are bench processes. A transaction-level reference model (idle /
// address / response phase, owner, read-or-write, last owner) is advanced from
// the bench's own stimulus only. Every cycle it predicts the grant, all
// ready/valid outputs and the forwarded payloads.
// -----------------------------------------------------------------------------
module tb_axi_lite_arb2;

   logic        clk;
   logic        rst;

   // master-side stimulus, indexed by master
   logic [31:0] arAddr [2];
   logic [31:0] awAddr [2];
   logic [31:0] wData  [2];
   logic [3:0]  wStrb  [2];
   logic        arV    [2];
   logic        awV    [2];
   logic        wV     [2];
   logic        rRdy   [2];
   logic        bRdy   [2];

   // slave-side stimulus
   logic        sArRdy, sAwRdy, sWRdy, sRV, sBV;
   logic [31:0] sRdata;
   logic [1:0]  sRresp, sBresp;

   // DUT outputs
   logic        m0_arready, m0_rvalid, m0_awready, m0_wready, m0_bvalid;
   logic        m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic [1:0]  m0_rresp, m1_rresp, m0_bresp, m1_bresp;
   logic [31:0] s_araddr, s_awaddr, s_wdata;
   logic [3:0]  s_wstrb;
   logic        s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
   logic [1:0]  grant;

   // reference model: phase 0 idle, 1 address, 2 response
   int          mdPhase;
   int          mdOwn;
   bit          mdRd;
   int          mdLast;

   // bench master / slave bookkeeping
   int          rdSt [2];   // 0 none, 1 AR valid, 2 awaiting R
   int          wrSt [2];   // 0 none, 1 AW only, 2 AW+W valid, 3 awaiting B
   int          wDly [2];
   int          sLat;
   int          pRd  [2];
   int          pWr  [2];
   int          wMax;

   int          testsRun;
   int          failCount;
   int          doneTx;

   axi_lite_arb2 #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .m0_araddr  (arAddr[0]),
      .m0_arvalid (arV[0]),
      .m0_arready (m0_arready),
      .m0_rdata   (m0_rdata),
      .m0_rresp   (m0_rresp),
      .m0_rvalid  (m0_rvalid),
      .m0_rready  (rRdy[0]),
      .m0_awaddr  (awAddr[0]),
      .m0_awvalid (awV[0]),
      .m0_awready (m0_awready),
      .m0_wdata   (wData[0]),
      .m0_wstrb   (wStrb[0]),
      .m0_wvalid  (wV[0]),
      .m0_wready  (m0_wready),
      .m0_bresp   (m0_bresp),
      .m0_bvalid  (m0_bvalid),
      .m0_bready  (bRdy[0]),
      .m1_araddr  (arAddr[1]),
      .m1_arvalid (arV[1]),
      .m1_arready (m1_arready),
      .m1_rdata   (m1_rdata),
      .m1_rresp   (m1_rresp),
      .m1_rvalid  (m1_rvalid),
      .m1_rready  (rRdy[1]),
      .m1_awaddr  (awAddr[1]),
      .m1_awvalid (awV[1]),
      .m1_awready (m1_awready),
      .m1_wdata   (wData[1]),
      .m1_wstrb   (wStrb[1]),
      .m1_wvalid  (wV[1]),
      .m1_wready  (m1_wready),
      .m1_bresp   (m1_bresp),
      .m1_bvalid  (m1_bvalid),
      .m1_bready  (bRdy[1]),
      .s_araddr   (s_araddr),
      .s_arvalid  (s_arvalid),
      .s_arready  (sArRdy),
      .s_rdata    (sRdata),
      .s_rresp    (sRresp),
      .s_rvalid   (sRV),
      .s_rready   (s_rready),
      .s_awaddr   (s_awaddr),
      .s_awvalid  (s_awvalid),
      .s_awready  (sAwRdy),
      .s_wdata    (s_wdata),
      .s_wstrb    (s_wstrb),
      .s_wvalid   (s_wvalid),
      .s_wready   (sWRdy),
      .s_bresp    (sBresp),
      .s_bvalid   (sBV),
      .s_bready   (s_bready),
      .grant      (grant)
   );

   // free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, act, exp);
      end
   endtask

   // advance the reference model by the handshakes that happened at the
   // posedge just passed, using only the bench's own driven values
   task automatic stepModel();
      int o;
      bit hs;
      bit req [2];
      o  = mdOwn;
      hs = 1'b0;
      case (mdPhase)
         0: begin
            for (int i = 0; i < 2; i++) req[i] = arV[i] | (awV[i] & wV[i]);
            if (req[0] | req[1]) begin
               if (req[0] & req[1]) o = 1 - mdLast;
               else                 o = req[1] ? 1 : 0;
               mdOwn   = o;
               mdLast  = o;
               mdRd    = arV[o];
               mdPhase = 1;
            end
         end
         1: begin
            if (mdRd) hs = arV[o] & sArRdy;
            else      hs = awV[o] & wV[o] & sAwRdy & sWRdy;
            if (hs) begin
               mdPhase = 2;
               sLat    = $urandom_range(0, 3);
               if (mdRd) begin
                  arV[o]  = 1'b0;
                  rdSt[o] = 2;
               end else begin
                  awV[o]  = 1'b0;
                  wV[o]   = 1'b0;
                  wrSt[o] = 3;
               end
            end
         end
         default: begin
            if (mdRd) hs = sRV & rRdy[o];
            else      hs = sBV & bRdy[o];
            if (hs) begin
               mdPhase = 0;
               doneTx++;
               if (mdRd) begin
                  sRV     = 1'b0;
                  rdSt[o] = 0;
               end else begin
                  sBV     = 1'b0;
                  wrSt[o] = 0;
               end
            end
         end
      endcase
   endtask

   // drive the next cycle's inputs: new master requests, delayed W halves,
   // random readies and the slave's latency-delayed responses
   task automatic applyStimulus();
      for (int i = 0; i < 2; i++) begin
         if (rdSt[i] == 0 && $urandom_range(0, 99) < pRd[i]) begin
            arV[i]    = 1'b1;
            arAddr[i] = $urandom;
            rdSt[i]   = 1;
         end
         if (wrSt[i] == 0 && $urandom_range(0, 99) < pWr[i]) begin
            awV[i]    = 1'b1;
            awAddr[i] = $urandom;
            wData[i]  = $urandom;
            wStrb[i]  = 4'($urandom_range(0, 15));
            wDly[i]   = $urandom_range(0, wMax);
            wrSt[i]   = 1;
         end
         if (wrSt[i] == 1) begin
            if (wDly[i] == 0) begin
               wV[i]   = 1'b1;
               wrSt[i] = 2;
            end else begin
               wDly[i]--;
            end
         end
         rRdy[i] = ($urandom_range(0, 9) < 7);
         bRdy[i] = ($urandom_range(0, 9) < 7);
      end
      sArRdy = ($urandom_range(0, 9) < 6);
      sAwRdy = ($urandom_range(0, 9) < 7);
      sWRdy  = ($urandom_range(0, 9) < 7);
      if (mdPhase == 2 && mdRd && !sRV) begin
         if (sLat == 0) begin
            sRV    = 1'b1;
            sRdata = $urandom;
            sRresp = 2'($urandom_range(0, 3));
         end else begin
            sLat--;
         end
      end
      if (mdPhase == 2 && !mdRd && !sBV) begin
         if (sLat == 0) begin
            sBV    = 1'b1;
            sBresp = 2'($urandom_range(0, 3));
         end else begin
            sLat--;
         end
      end
      if (!sRV) sRdata = $urandom;
   endtask

   // compare every DUT output against the model's prediction for this cycle
   task automatic checkAll();
      logic [1:0] eGrant;
      logic [4:0] eSlave;
      logic [4:0] eM [2];
      int         o;
      o      = mdOwn;
      eGrant = 2'b00;
      eSlave = 5'b0;
      eM[0]  = 5'b0;
      eM[1]  = 5'b0;
      // vectors: slave {arvalid, awvalid, wvalid, rready, bready}
      //          master {arready, rvalid, awready, wready, bvalid}
      if (mdPhase != 0) eGrant = (o == 1) ? 2'b10 : 2'b01;
      if (mdPhase == 1 && mdRd) begin
         eSlave[4] = arV[o];
         eM[o][4]  = sArRdy;
      end
      if (mdPhase == 1 && !mdRd) begin
         eSlave[3] = awV[o] & wV[o];
         eSlave[2] = awV[o] & wV[o];
         eM[o][2]  = sAwRdy & sWRdy;
         eM[o][1]  = sAwRdy & sWRdy;
      end
      if (mdPhase == 2 && mdRd) begin
         eSlave[1] = rRdy[o];
         eM[o][3]  = sRV;
      end
      if (mdPhase == 2 && !mdRd) begin
         eSlave[0] = bRdy[o];
         eM[o][0]  = sBV;
      end
      checkOutput("grant", {30'b0, grant}, {30'b0, eGrant});
      checkOutput("slaveCtl", {27'b0, s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}, {27'b0, eSlave});
      checkOutput("m0Ctl", {27'b0, m0_arready, m0_rvalid, m0_awready, m0_wready, m0_bvalid}, {27'b0, eM[0]});
      checkOutput("m1Ctl", {27'b0, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid}, {27'b0, eM[1]});
      if (eSlave[4]) checkOutput("araddr", s_araddr, arAddr[o]);
      if (eSlave[3]) begin
         checkOutput("awaddr", s_awaddr, awAddr[o]);
         checkOutput("wdata", s_wdata, wData[o]);
         checkOutput("wstrb", {28'b0, s_wstrb}, {28'b0, wStrb[o]});
      end
      if (eM[o][3]) begin
         checkOutput("rdata", (o == 1) ? m1_rdata : m0_rdata, sRdata);
         checkOutput("rresp", {30'b0, (o == 1) ? m1_rresp : m0_rresp}, {30'b0, sRresp});
      end
      if (eM[o][0]) checkOutput("bresp", {30'b0, (o == 1) ? m1_bresp : m0_bresp}, {30'b0, sBresp});
   endtask

   // one bench cycle per iteration: model step, new stimulus, settle, check
   task automatic runCycles(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         stepModel();
         applyStimulus();
         #1;
         checkAll();
      end
   endtask

   task automatic setMix(input int rd0, input int rd1, input int wr0, input int wr1, input int wm);
      pRd[0] = rd0;
      pRd[1] = rd1;
      pWr[0] = wr0;
      pWr[1] = wr1;
      wMax   = wm;
   endtask

   initial begin
      testsRun  = 0;
      failCount = 0;
      doneTx    = 0;
      mdPhase   = 0;
      mdOwn     = 0;
      mdRd      = 1'b0;
      mdLast    = 1;
      sLat      = 0;
      for (int i = 0; i < 2; i++) begin
         arAddr[i] = '0; awAddr[i] = '0; wData[i] = '0; wStrb[i] = '0;
         arV[i] = 1'b0; awV[i] = 1'b0; wV[i] = 1'b0;
         rRdy[i] = 1'b1; bRdy[i] = 1'b1;
         rdSt[i] = 0; wrSt[i] = 0; wDly[i] = 0;
      end
      sArRdy = 1'b1; sAwRdy = 1'b1; sWRdy = 1'b1;
      sRV = 1'b0; sBV = 1'b0; sRdata = '0; sRresp = '0; sBresp = '0;
      setMix(0, 0, 0, 0, 0);

      // requests present during reset must not be forwarded. They form a tie
      // when reset drops, so M0's read must win first.
      rst       = 1'b1;
      arV[0]    = 1'b1;
      arAddr[0] = 32'h8000_0004;
      rdSt[0]   = 1;
      awV[1]    = 1'b1;
      wV[1]     = 1'b1;
      awAddr[1] = 32'h8000_0010;
      wData[1]  = 32'h1234_5678;
      wStrb[1]  = 4'hF;
      wrSt[1]   = 2;
      #1;
      checkAll();
      repeat (2) begin
         @(negedge clk);
         #1;
         checkAll();
      end
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] M0 reads only");
      setMix(60, 0, 0, 0, 0);
      runCycles(60);

      $display("[TB] M1 writes only");
      setMix(0, 0, 0, 60, 0);
      runCycles(60);

      $display("[TB] read contention");
      setMix(100, 100, 0, 0, 0);
      runCycles(60);

      $display("[TB] M1 read and write together");
      setMix(0, 100, 0, 100, 0);
      runCycles(60);

      $display("[TB] split writes on M1 with M0 reads");
      setMix(100, 0, 0, 100, 6);
      runCycles(80);

      $display("[TB] reset during read data phase");
      setMix(100, 0, 0, 0, 0);
      for (int k = 0; k < 200 && !(mdPhase == 2 && mdRd); k++) runCycles(1);
      rst     = 1'b1;
      mdPhase = 0;
      mdLast  = 1;
      #1;
      checkAll();
      for (int i = 0; i < 2; i++) begin
         arV[i] = 1'b0; awV[i] = 1'b0; wV[i] = 1'b0;
         rdSt[i] = 0; wrSt[i] = 0;
      end
      sRV = 1'b0;
      sBV = 1'b0;
      repeat (2) begin
         @(negedge clk);
         #1;
         checkAll();
      end
      @(negedge clk);
      rst = 1'b0;
      runCycles(40);

      $display("[TB] random mix");
      setMix(50, 50, 50, 50, 3);
      runCycles(3000);

      $display("[TB] %0d transactions completed", doneTx);
      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule

// File: doc/axi_lite_arb2.md
# axi_lite_arb2

Two-master, one-slave AXI4-Lite arbiter placed between the core's instruction fetch unit (master 0) and load/store unit (master 1) and the shared memory slave. It serialises traffic so the slave sees at most one outstanding transaction, read or write, at a time. It uses round-robin selection between masters and routes each response back to the master that issued the request.

## Interface
- ADDR_W, 32, address width of all AR/AW channels
- DATA_W, 32, data width of all R/W channels; strobe width DATA_W/8

Ports (per channel; i ∈ {0,1}):
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset rst, asynchronous, active-high; clock clk
- m<i>_araddr in ADDR_W / m<i>_arvalid in 1 / m<i>_arready out 1  master i read address
- m<i>_rdata out DATA_W / m<i>_rresp out 2 / m<i>_rvalid out 1 / m<i>_rready in 1  master i read data
- m<i>_awaddr in ADDR_W / m<i>_awvalid in 1 / m<i>_awready out 1  master i write address
- m<i>_wdata in DATA_W / m<i>_wstrb in DATA_W/8 / m<i>_wvalid in 1 / m<i>_wready out 1  master i write data
- m<i>_bresp out 2 / m<i>_bvalid out 1 / m<i>_bready in 1  master i write response
- s_araddr/s_arvalid out, s_arready in  slave read address, same widths
- s_rdata/s_rresp/s_rvalid in, s_rready out  slave read data
- s_awaddr/s_awvalid out, s_awready in  slave write address
- s_wdata/s_wstrb/s_wvalid out, s_wready in  slave write data
- s_bresp/s_bvalid in, s_bready out  slave write response
- grant  out  2  one-hot owner of current transaction, 0 when idle (debug/perf)

## Operation
- Request from master i: rd_req_i = m<i>_arvalid; wr_req_i = m<i>_awvalid & m<i>_wvalid. A write is only recognised when AW and W are both valid, because the slave accepts them only in the same cycle.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP.
- IDLE: pick the master with any request.
  - If both masters request, the master != last_owner wins. last_owner resets to 1, so M0 wins the first tie.
  - Within the chosen master, a read beats a write when both are pending.
  - Latch owner and last_owner, then go to RD_ADDR or WR_ADDR.
- RD_ADDR:
  - s_araddr = owner's araddr; s_arvalid = owner's arvalid; owner's arready = s_arready.
  - On s_arvalid & s_arready, go to RD_DATA.
- RD_DATA:
  - Owner's rdata/rresp/rvalid = slave's; s_rready = owner's rready.
  - On the R handshake, go to IDLE.
- WR_ADDR:
  - s_aw*/s_w* come from owner; s_awvalid = s_wvalid = owner awvalid & wvalid.
  - Owner awready = wready = s_awready & s_wready.
  - On the joint handshake, go to WR_RESP.
- WR_RESP:
  - B channel routed to owner.
  - On the B handshake, go to IDLE.
- The non-owner sees all ready/valid outputs at 0. rresp/bresp pass through unmodified (no error generation).
- Payload outputs (addr/data/strb) are don't-care while the matching valid is 0; drive them from the owner mux regardless.

## Timing
- Reset values (async): state=IDLE, owner=none, last_owner=1, grant=0. Every valid/ready output is 0 during and after reset until the arbiter leaves IDLE.
- Arbitration costs exactly 1 cycle: the request is sampled in IDLE, and forwarding starts in the next cycle.
- Forwarding in the non-IDLE states is combinational (zero added latency per channel).
- Best case per transaction: 1 (arb) + 1 (addr handshake) + 1 (response handshake) = 3 cycles. Add slave latency on top.
- No new arbitration until the response handshake completes. The return to IDLE costs no extra cycle beyond arbitration, so back-to-back transactions are ≥3 cycles apart.
- The non-owner's request must stay asserted; valid held with no ready is legal AXI. Round-robin bounds its wait to one transaction.
- A request deasserted before grant is simply not seen. Requests withdrawn after grant violate AXI and are undefined.
- rst asserted mid-transaction returns to IDLE immediately and drops all valids. The slave shares rst and must be reset together.

## Test plan
- Single read:
  - Stimulus: M0 arvalid, araddr=0x8000_0004; slave returns rdata=0xDEADBEEF after 3 cycles.
  - Required: M0 gets rvalid with 0xDEADBEEF; s_arvalid first high 1 cycle after arvalid; m1 outputs stay 0.
- Single write:
  - Stimulus: M1 aw/w valid, awaddr=0x8000_0010, wdata=0x12345678, wstrb=0xF.
  - Required: s_awvalid and s_wvalid rise together; bresp=0 returned to M1 only; M0 bvalid stays 0.
- Contention:
  - Stimulus: M0 and M1 both assert arvalid continuously for 4 transactions.
  - Required: grant sequence 01,10,01,10; M0 served first.
- Read/write priority:
  - Stimulus: M1 has arvalid and awvalid&wvalid together.
  - Required: read completes first, then the write.
- Split write:
  - Stimulus: M1 awvalid=1, wvalid=0 for 5 cycles, then wvalid=1.
  - Required: no grant while wvalid=0; a concurrent M0 read is served meanwhile.
- Reset mid-transaction:
  - Stimulus: assert rst in RD_DATA.
  - Required: grant=0 and all valids/readys 0 in the same cycle; a fresh read after reset completes normally.
